// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
//
// Round-robin sequencer for the shared 8-bit ALU datapath. Two requesters hand
// in {opcode, A, B} commands over valid/ready. A granted legal command loads the
// operand/select registers that feed the datapath. After LATENCY cycles the
// result-multiplexor output is captured and returned, tagged with the requester
// id, on a single valid/ready response channel. Illegal opcodes (5..7) skip the
// datapath and answer at once with rsp_err_o set.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   reqN_valid_i/op_i/a_i/b_i     command from requester N (N = 0, 1)
//   reqN_ready_o                  command from requester N accepted this cycle
//   alu_a_o, alu_b_o, alu_ctrl_o  registered operands and mux select
//   alu_result_i                  result-multiplexor output
//   rsp_valid_o/ready_i           response handshake
//   rsp_id_o, rsp_data_o, rsp_err_o  response payload
//   busy_o                        scheduler is not idle
//
// LATENCY must be 1..7 (3-bit counter); other values are not supported.
// -----------------------------------------------------------------------------
module alu_op_scheduler #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_valid_i,
  input  logic [2:0] req0_op_i,
  input  logic [7:0] req0_a_i,
  input  logic [7:0] req0_b_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [2:0] req1_op_i,
  input  logic [7:0] req1_a_i,
  input  logic [7:0] req1_b_i,
  output logic       req1_ready_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [2:0] alu_ctrl_o,
  input  logic [7:0] alu_result_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);
  localparam logic [2:0] OP_MAX   = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  // ---------------------------------------------------------------------------
  // Command selection and arbitration
  // ---------------------------------------------------------------------------
  cmd_t       cmd0, cmd1, cmd_sel;
  logic [1:0] gnt;
  logic       acc;
  logic       acc_id;
  logic       legal;

  assign cmd0 = '{op: req0_op_i, a: req0_a_i, b: req0_b_i};
  assign cmd1 = '{op: req1_op_i, a: req1_a_i, b: req1_b_i};

  // Grant only in IDLE. Under contention the requester that did not win last
  // time goes first. Readies are also held low while reset is asserted so that
  // no handshake can appear to complete during reset.
  always_comb begin
    gnt = 2'b00;
    if (rst_ni && (state_q == IDLE)) begin
      gnt[0] = req0_valid_i && (!req1_valid_i ||  last_grant_q);
      gnt[1] = req1_valid_i && (!req0_valid_i || !last_grant_q);
    end
  end

  assign acc     = |gnt;
  assign acc_id  = gnt[1];
  assign cmd_sel = acc_id ? cmd1 : cmd0;
  assign legal   = (cmd_sel.op <= OP_MAX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          last_grant_d = acc_id;
          id_d         = acc_id;
          if (legal) begin
            alu_a_d    = cmd_sel.a;
            alu_b_d    = cmd_sel.b;
            alu_ctrl_d = cmd_sel.op;
            cnt_d      = CNT_LOAD;
            state_d    = EXEC;
          end else begin
            // Illegal op never touches the datapath registers.
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end

      EXEC: begin
        // The counter reaching zero marks the edge where the datapath result
        // is LATENCY cycles old relative to the operand load.
        if (cnt_q == 3'd0) begin
          rsp_data_d = alu_result_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      id_q         <= 1'b0;
      cnt_q        <= 3'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_ctrl_q   <= 3'd0;
      rsp_data_q   <= 8'h00;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule
